// File: rtl/mole_driver.sv
// Whack-a-mole round driver: picks a pseudo-random target, lights it for a
// bounded window and reports whether the player struck the right button.
module mole_driver #(
  parameter int         WINDOW = 8,
  parameter logic [7:0] SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [3:0] buttons,
  output logic [3:0] leds,
  output logic [1:0] target,
  output logic       busy,
  output logic       result_valid,
  output logic       hit
);

  localparam int CW = $clog2(WINDOW);

  typedef enum logic [1:0] {IDLE, ARM, SHOW, REPORT} state_e;

  state_e          state_q;
  logic [7:0]      lfsr_q;
  logic [7:0]      lfsr_d;
  logic [3:0]      sync1_q;
  logic [3:0]      bsync_q;
  logic [3:0]      bprev_q;
  logic [3:0]      press_d;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      target_q;
  logic [1:0]      pick_d;
  logic [3:0]      leds_q;
  logic            busy_q;
  logic            valid_q;
  logic            hit_q;

  // Taps 8,6,5,4 of the polynomial map onto register bits 7,5,4,3.
  assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign press_d = bsync_q & ~bprev_q;
  // Never repeat the previous target back-to-back.
  assign pick_d  = (lfsr_q[1:0] == target_q) ? lfsr_q[1:0] + 2'd1 : lfsr_q[1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      sync1_q  <= '0;
      bsync_q  <= '0;
      bprev_q  <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      leds_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      sync1_q <= buttons;
      bsync_q <= sync1_q;
      bprev_q <= bsync_q;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q  <= ARM;
            target_q <= pick_d;
            busy_q   <= 1'b1;
          end
        end
        ARM: begin
          // Buttons still held from before the round must be released first.
          if (bsync_q == 4'b0000) begin
            state_q <= SHOW;
            cnt_q   <= '0;
            leds_q  <= 4'b0001 << target_q;
          end
        end
        SHOW: begin
          if (press_d != 4'b0000) begin
            state_q <= REPORT;
            hit_q   <= (press_d == (4'b0001 << target_q));
            valid_q <= 1'b1;
            leds_q  <= '0;
          end else if (cnt_q == CW'(WINDOW - 1)) begin
            state_q <= REPORT;
            hit_q   <= 1'b0;
            valid_q <= 1'b1;
            leds_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        REPORT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign leds         = leds_q;
  assign target       = target_q;
  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign hit          = hit_q;

endmodule

// File: tb/tb_mole_driver.sv
// Bench for mole_driver: directed and randomized rounds checked against a
// round-level model of target selection, display timing and scoring.
module tb_mole_driver;

  localparam int         W    = 8;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [3:0] buttons;
  logic [3:0] leds;
  logic [1:0] target;
  logic       busy;
  logic       result_valid;
  logic       hit;

  int         vectors    = 0;
  int         miscompares = 0;
  int         cyc        = 0;
  logic [1:0] prev_t     = 2'd0;
  logic       last_hit   = 1'b0;
  logic [3:0] seen       = 4'b0000;
  logic [1:0] prev_obs   = 2'd0;
  int         rounds     = 0;

  mole_driver #(.WINDOW(W), .SEED(SEED)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .buttons      (buttons),
    .leds         (leds),
    .target       (target),
    .busy         (busy),
    .result_valid (result_valid),
    .hit          (hit)
  );

  always #5 clk = ~clk;

  // LFSR state after n free-running steps from SEED, from the polynomial.
  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] v;
    v = SEED;
    for (int i = 0; i < n; i++) v = {v[6:0], ^(v & 8'hB8)};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) cyc++;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] next_target();
    logic [7:0] l;
    logic [1:0] t;
    l = lfsr_at(cyc);
    t = l[1:0];
    if (t == prev_t) t = t + 2'd1;
    return t;
  endfunction

  task automatic issue_req(input logic [1:0] t);
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("busy_arm", busy, 1);
    chk("target", target, t);
    chk("leds_arm", leds, 0);
    chk("no_repeat", (target != prev_obs), 1);
    seen[target] = 1'b1;
    prev_obs = target;
  endtask

  // Count SHOW cycles until the result pulse; a pure timeout lasts W cycles.
  task automatic finish_timeout(input logic [1:0] t);
    int n;
    n = 1;
    while (!result_valid && n < 4 * W) begin
      tick();
      if (!result_valid) begin
        if (leds !== (4'b0001 << t)) chk("leds_show_hold", leds, 4'b0001 << t);
        n++;
      end
    end
    chk("show_len", n, W);
    chk("rv_timeout", result_valid, 1);
    chk("hit_timeout", hit, 0);
    chk("leds_report", leds, 0);
    last_hit = 1'b0;
  endtask

  task automatic close_round(input logic [1:0] t);
    tick();
    chk("rv_pulse_end", result_valid, 0);
    chk("busy_idle", busy, 0);
    chk("hit_hold", hit, last_hit);
    buttons = 4'b0000;
    repeat (4) tick();
    chk("hit_hold_idle", hit, last_hit);
    prev_t = t;
    rounds++;
  endtask

  // kind: 0 timeout, 1 target, 2 target+neighbour, 3 wrong single, 4 random
  task automatic round(input int kind, input int d);
    logic [1:0] t;
    logic [3:0] pat;
    int         n;
    int         exp_n;
    logic       exp_hit;
    t = next_target();
    issue_req(t);
    n = 0;
    while (leds == 4'b0000 && n < 20) begin
      tick();
      n++;
    end
    chk("arm_len", n, 1);
    chk("leds_show", leds, 4'b0001 << t);
    if (kind == 0) begin
      finish_timeout(t);
    end else begin
      case (kind)
        1:       pat = 4'b0001 << t;
        2:       pat = (4'b0001 << t) | (4'b0001 << 2'(t + 2'd1));
        3:       pat = 4'b0001 << 2'(t + 2'(1 + $urandom_range(0, 2)));
        default: pat = 4'($urandom_range(1, 15));
      endcase
      repeat (d) tick();
      buttons = pat;
      if (d + 3 <= W) begin
        exp_n   = 3;
        exp_hit = (pat == (4'b0001 << t));
      end else begin
        exp_n   = W - d;
        exp_hit = 1'b0;
      end
      n = 0;
      while (!result_valid && n < 4 * W) begin
        tick();
        n++;
      end
      chk("press_latency", n, exp_n);
      chk("rv_press", result_valid, 1);
      chk("hit_press", hit, exp_hit);
      chk("leds_report", leds, 0);
      chk("busy_report", busy, 1);
      last_hit = exp_hit;
    end
    close_round(t);
  endtask

  initial begin
    logic [1:0] t;
    int         n;
    rst = 1'b0;
    req = 1'b0;
    buttons = 4'b0000;
    repeat (3) tick();
    chk("rst_leds", leds, 0);
    chk("rst_target", target, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_hit", hit, 0);
    rst = 1'b1;
    cyc = 0;
    tick();
    chk("idle_busy", busy, 0);

    round(0, 0);
    round(1, 0);
    round(2, 1);
    round(1, W - 3);
    round(3, 2);

    // Button held across the request: ARM must wait for release, no press.
    buttons = 4'b0001;
    repeat (3) tick();
    t = next_target();
    issue_req(t);
    repeat (4) begin
      tick();
      chk("held_arm_leds", leds, 0);
      chk("held_arm_busy", busy, 1);
    end
    buttons = 4'b0000;
    n = 0;
    while (leds == 4'b0000 && n < 20) begin
      tick();
      n++;
    end
    chk("held_release_lat", n, 3);
    chk("held_leds_show", leds, 4'b0001 << t);
    finish_timeout(t);
    close_round(t);

    for (int r = 0; r < 60; r++) begin
      if (r >= 20 && seen == 4'b1111) break;
      round($urandom_range(0, 4), $urandom_range(0, W - 1));
      repeat ($urandom_range(0, 5)) tick();
    end
    chk("all_targets_seen", seen, 4'b1111);

    // Abort mid-SHOW at counter 3.
    t = next_target();
    issue_req(t);
    tick();
    chk("abort_show", leds, 4'b0001 << t);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("abort_leds", leds, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rv", result_valid, 0);
    chk("abort_target", target, 0);
    chk("abort_hit", hit, 0);
    rst = 1'b1;
    cyc = 0;
    prev_t = 2'd0;
    prev_obs = 2'd3;
    last_hit = 1'b0;
    round(1, 0);
    round(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mole_driver.md
MOLE_DRIVER -- requirements
Module: mole_driver

Interface
REQ-001 Parameter: WINDOW, default 8, SHOW-state duration in clk cycles (min 2).
REQ-002 Parameter: SEED, default 8'hA5, LFSR reset value (nonzero).
REQ-003 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-low.
REQ-005 Port: req  input  1  one-cycle round request from game controller.
REQ-006 Port: buttons  input  4  player buttons, active-high, asynchronous to clk.
REQ-007 Port: leds  output  4  one-hot target display, lit only in SHOW.
REQ-008 Port: target  output  2  index of current target.
REQ-009 Port: busy  output  1  high whenever state is not IDLE.
REQ-010 Port: result_valid  output  1  one-cycle pulse carrying round outcome.
REQ-011 Port: hit  output  1  outcome: 1 = hit, 0 = miss; meaningful only while result_valid=1.

Function
REQ-012 Each buttons bit SHALL pass through a 2-flop synchronizer, producing bsync.
REQ-013 A press event SHALL be bsync & ~bprev, where bprev is bsync delayed one cycle.
REQ-014 The 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) SHALL advance every cycle in every state.
REQ-015 FSM states SHALL be IDLE, ARM, SHOW and REPORT, all registered.
REQ-016 IDLE: req=1 -> ARM on the next edge, and target latches lfsr[1:0] at that edge.
REQ-017 If lfsr[1:0] equals the previous target, target SHALL instead latch (lfsr[1:0]+1) mod 4.
REQ-018 req SHALL be ignored in ARM, SHOW and REPORT, with no queuing.
REQ-019 ARM: leds=0; the FSM stays in ARM while bsync!=0 and moves to SHOW on the first cycle bsync==0.
REQ-020 The window counter SHALL clear on entry to SHOW and increment each SHOW cycle.
REQ-021 SHOW: leds = 1<<target.
REQ-022 SHOW, press event on the target bit only -> REPORT with hit=1.
REQ-023 SHOW, press event on any non-target bit, including simultaneous with the target bit -> REPORT with hit=0.
REQ-024 SHOW with no press event and counter==WINDOW-1 -> REPORT with hit=0 (timeout).
REQ-025 If a press and the timeout occur in the same cycle, the press rule SHALL take precedence.
REQ-026 REPORT: result_valid=1 and leds=0 for exactly one cycle, then IDLE.
REQ-027 hit SHALL hold its value until the next REPORT.
REQ-028 Counter width SHALL be clog2(WINDOW), and it SHALL never wrap inside a round.
REQ-029 busy SHALL be 0 only in IDLE.
REQ-030 The minimum req-to-result_valid latency SHALL be 3 cycles (ARM, SHOW, REPORT).

Reset
REQ-031 While rst=0 at an edge: state=IDLE, leds=0, target=0, previous target=0, hit=0, result_valid=0, busy=0, counter=0, lfsr=SEED, synchronizer and bprev flops=0.
REQ-032 Reset asserted mid-round SHALL abort the round, with no result_valid pulse, and return to IDLE on that edge.
REQ-033 The first req after reset release SHALL be honored normally.

Verification
REQ-034 Buttons idle, req pulse -> busy=1 next cycle; ARM 1 cycle; leds one-hot for exactly 8 cycles; result_valid=1 with hit=0 on the following cycle; then busy=0.
REQ-035 In SHOW, assert buttons=1<<target -> result_valid=1 with hit=1 within 4 cycles; leds=0 in the REPORT cycle.
REQ-036 In SHOW, assert buttons=(1<<target)|(1<<((target+1)%4)) together -> hit=0.
REQ-037 Hold buttons=4'b0001 across req -> FSM stays in ARM with leds=0 until release, then enters SHOW; the held button produces no press event.
REQ-038 Run 20 consecutive rounds -> target never equals the previous target; all four indices appear.
REQ-039 Drive rst=0 during SHOW at counter=3 -> next cycle leds=0, busy=0, result_valid=0, lfsr=8'hA5.
